// File: rtl/mips_rf_pkg.sv
// Purpose: shared types and sizing constants for the multi-port register file.
// Contents: rf_state_t (sweep/run state), default widths, depth helper.
package mips_rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   // Number of registers addressed by an index of addr_w bits.
   function automatic int unsigned rf_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Purpose: decode/writeback-side bus of the register file.
// Signals: WE/WADDR/WDATA write port, RADDR packed read indices,
//          RDATA packed read data, READY clear-sweep-done flag.
// Modports: master = pipeline side, slave = register file side.
interface reg_file_mp_if
   import mips_rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NUM_RD = 2
);

   logic                       WE;
   logic [ADDR_W-1:0]          WADDR;
   logic [DATA_W-1:0]          WDATA;
   logic [NUM_RD*ADDR_W-1:0]   RADDR;
   logic [NUM_RD*DATA_W-1:0]   RDATA;
   logic                       READY;

   modport master (
      output WE, WADDR, WDATA, RADDR,
      input  RDATA, READY
   );

   modport slave (
      input  WE, WADDR, WDATA, RADDR,
      output RDATA, READY
   );

endinterface

// File: rtl/rf_read_port.sv
// Purpose: one combinational read port: zero register, write bypass,
//          then stored value; forced to 0 until the clear sweep is done.
// Ports: ready, raddr, wr_en/waddr/wdata (current write), stored
//        (array entry at raddr), rdata_c (combinational read data).
module rf_read_port
   import mips_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              ready,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] stored,
   output logic [DATA_W-1:0] rdata_c
);

   // Precedence: not ready, zero register, write-first bypass, array.
   always_comb begin
      rdata_c = stored;
      if (!ready) begin
         rdata_c = '0;
      end else if (ZERO_REG && (raddr == '0)) begin
         rdata_c = '0;
      end else if (BYPASS && wr_en && (waddr == raddr)) begin
         rdata_c = wdata;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Purpose: parametrised register file with NUM_RD asynchronous read ports,
//          one synchronous write port and a post-reset clear sweep.
// Ports: CLK, RST (synchronous, active-high), bus (reg_file_mp_if.slave):
//        WE/WADDR/WDATA write, RADDR/RDATA reads, READY sweep done.
module reg_file_mp
   import mips_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned NUM_RD   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   reg_file_mp_if.slave  bus
);

   localparam int unsigned DEPTH = rf_depth(ADDR_W);
   // One extra bit so the last sweep index never aliases index 0.
   localparam int unsigned CNT_W = ADDR_W + 1;

   rf_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   // Next state, sweep counter and the single array write port.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = ready_q;
      mem_we    = 1'b0;
      mem_waddr = bus.WADDR;
      mem_wdata = bus.WDATA;
      case (state_q)
         RF_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d = RF_RUN;
               ready_d = 1'b1;
            end
         end
         RF_RUN: begin
            mem_we = bus.WE && !(ZERO_REG && (bus.WADDR == '0));
         end
         default: begin
            state_d = RF_CLEAR;
         end
      endcase
      if (RST) begin
         state_d = RF_CLEAR;
         cnt_d   = '0;
         ready_d = 1'b0;
         mem_we  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
   end

   // Array has no reset term so it can map onto distributed RAM.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] rdata;

      assign raddr = bus.RADDR[i*ADDR_W +: ADDR_W];

      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .ready   (ready_q),
         .raddr   (raddr),
         .wr_en   (bus.WE),
         .waddr   (bus.WADDR),
         .wdata   (bus.WDATA),
         .stored  (mem_q[raddr]),
         .rdata_c (rdata)
      );

      assign bus.RDATA[i*DATA_W +: DATA_W] = rdata;
   end

   assign bus.READY = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three instances (default, no-zero/no-bypass,
// 4-port narrow) driven by directed vectors and checked against a model.
module tb_reg_file_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Shared stimulus for instances A and B.
   logic        we    = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  ra0   = '0;
   logic [4:0]  ra1   = '0;
   // Stimulus for instance C.
   logic        we_c    = 1'b0;
   logic [2:0]  waddr_c = '0;
   logic [15:0] wdata_c = '0;
   logic [2:0]  ra_c [4] = '{default: '0};

   reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa (), ifb ();
   reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ifc ();

   assign ifa.WE = we;    assign ifa.WADDR = waddr; assign ifa.WDATA = wdata;
   assign ifa.RADDR = {ra1, ra0};
   assign ifb.WE = we;    assign ifb.WADDR = waddr; assign ifb.WDATA = wdata;
   assign ifb.RADDR = {ra1, ra0};
   assign ifc.WE = we_c;  assign ifc.WADDR = waddr_c; assign ifc.WDATA = wdata_c;
   assign ifc.RADDR = {ra_c[3], ra_c[2], ra_c[1], ra_c[0]};

   reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut_a (.CLK(clk), .RST(rst), .bus(ifa));
   reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0))
      dut_b (.CLK(clk), .RST(rst), .bus(ifb));
   reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut_c (.CLK(clk), .RST(rst), .bus(ifc));

   // ---------------- behavioural model ----------------
   // run_cnt = edges since RST last seen high; the file is usable once it
   // reaches the register count, at which point every entry reads zero.
   int          run_cnt  = 0;
   bit          model_ok = 1'b0;
   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   logic [15:0] m_c [8];

   always @(posedge clk) begin
      if (rst) begin
         run_cnt  <= 0;
         model_ok <= 1'b1;
      end else begin
         if (run_cnt < 1000) run_cnt <= run_cnt + 1;
         if (run_cnt + 1 == 32) begin
            for (int k = 0; k < 32; k++) begin m_a[k] <= '0; m_b[k] <= '0; end
         end
         if (run_cnt + 1 == 8) begin
            for (int k = 0; k < 8; k++) m_c[k] <= '0;
         end
         if (run_cnt >= 32 && we) begin
            if (waddr != 5'd0) m_a[waddr] <= wdata;
            m_b[waddr] <= wdata;
         end
         if (run_cnt >= 8 && we_c && waddr_c != 3'd0) m_c[waddr_c] <= wdata_c;
      end
   end

   function automatic logic [31:0] exp_rd(input bit rdy, input bit zero, input bit byp,
                                          input int ra, input bit w, input int wa,
                                          input logic [31:0] wd, input logic [31:0] st);
      if (!rdy) return 32'd0;
      if (zero && ra == 0) return 32'd0;
      if (byp && w && wa == ra) return wd;
      return st;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("a_ready", 64'(ifa.READY), 64'(run_cnt >= 32));
         chk("b_ready", 64'(ifb.READY), 64'(run_cnt >= 32));
         chk("c_ready", 64'(ifc.READY), 64'(run_cnt >= 8));
         chk("a_rd0", 64'(ifa.RDATA[31:0]),
             64'(exp_rd(run_cnt >= 32, 1'b1, 1'b1, int'(ra0), we, int'(waddr), wdata, m_a[ra0])));
         chk("a_rd1", 64'(ifa.RDATA[63:32]),
             64'(exp_rd(run_cnt >= 32, 1'b1, 1'b1, int'(ra1), we, int'(waddr), wdata, m_a[ra1])));
         chk("b_rd0", 64'(ifb.RDATA[31:0]),
             64'(exp_rd(run_cnt >= 32, 1'b0, 1'b0, int'(ra0), we, int'(waddr), wdata, m_b[ra0])));
         chk("b_rd1", 64'(ifb.RDATA[63:32]),
             64'(exp_rd(run_cnt >= 32, 1'b0, 1'b0, int'(ra1), we, int'(waddr), wdata, m_b[ra1])));
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("c_rd%0d", p), 64'(ifc.RDATA[p*16 +: 16]),
                64'(16'(exp_rd(run_cnt >= 8, 1'b1, 1'b1, int'(ra_c[p]), we_c, int'(waddr_c),
                               32'(wdata_c), 32'(m_c[ra_c[p]])))));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Cycles from RST release until READY on A (bounded) and on C.
   task automatic wait_ready(output int n_a, output int n_c);
      n_a = 0;
      n_c = -1;
      while (ifa.READY !== 1'b1 && n_a < 40) begin
         cyc();
         n_a++;
         if (n_c < 0 && ifc.READY === 1'b1) n_c = n_a;
      end
   endtask

   logic [15:0] exp_c1 [4] = '{16'h1111, 16'h3333, 16'h5555, 16'h7777};
   logic [15:0] exp_c2 [4] = '{16'h2222, 16'h4444, 16'h6666, 16'h0000};

   initial begin
      int na, nc;
      // Reset sweep with a write attempt that must be ignored.
      rst = 1'b1;
      cyc(); cyc();
      #1 chk("rst_ready", 64'(ifa.READY), 64'd0);
      chk("rst_rdata", 64'(ifa.RDATA), 64'd0);
      rst = 1'b0;
      we = 1'b1; waddr = 5'd5; wdata = 32'h0000DEAD;
      we_c = 1'b1; waddr_c = 3'd5; wdata_c = 16'hDEAD;
      wait_ready(na, nc);
      we = 1'b0; we_c = 1'b0;
      chk("sweep_len_a", 64'(na), 64'd32);
      chk("sweep_len_c", 64'(nc), 64'd8);
      for (int r = 0; r < 32; r++) begin
         ra0 = 5'(r); ra1 = 5'(31 - r);
         #1;
         chk("clr_a", 64'(ifa.RDATA), 64'd0);
         chk("clr_b", 64'(ifb.RDATA), 64'd0);
         cyc();
      end

      // Same-cycle read without bypass sees old value; with bypass sees new.
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; ra0 = 5'd7; ra1 = 5'd7;
      #1 chk("nobyp_old", 64'(ifb.RDATA[31:0]), 64'd0);
      chk("byp_new7", 64'(ifa.RDATA[31:0]), 64'h12345678);
      cyc(); we = 1'b0;
      #1 chk("b_r7_p0", 64'(ifb.RDATA[31:0]), 64'h12345678);
      chk("b_r7_p1", 64'(ifb.RDATA[63:32]), 64'h12345678);

      // Bypass on one port while the other reads a stored register.
      we = 1'b1; waddr = 5'd3; wdata = 32'h00000033;
      cyc();
      waddr = 5'd9; wdata = 32'hCAFEF00D; ra0 = 5'd9; ra1 = 5'd3;
      #1 chk("byp_r9", 64'(ifa.RDATA[31:0]), 64'hCAFEF00D);
      chk("byp_r3", 64'(ifa.RDATA[63:32]), 64'h33);
      chk("nobyp_r9", 64'(ifb.RDATA[31:0]), 64'd0);
      cyc(); we = 1'b0;

      // Writes to register 0.
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra0 = 5'd0; ra1 = 5'd0;
      #1 chk("zero_byp", 64'(ifa.RDATA[31:0]), 64'd0);
      chk("nozero_old", 64'(ifb.RDATA[31:0]), 64'd0);
      cyc(); we = 1'b0;
      #1 chk("zero_after", 64'(ifa.RDATA), 64'd0);
      chk("nozero_after", 64'(ifb.RDATA[63:32]), 64'hFFFFFFFF);
      cyc(); cyc();
      #1 chk("zero_later", 64'(ifa.RDATA[31:0]), 64'd0);

      // Reset while running, then again mid-sweep at sweep cycle 10.
      rst = 1'b1; cyc(); rst = 1'b0;
      repeat (10) cyc();
      #1 chk("midsweep_rdy", 64'(ifa.READY), 64'd0);
      rst = 1'b1; cyc(); rst = 1'b0;
      wait_ready(na, nc);
      chk("resweep_len_a", 64'(na), 64'd32);
      chk("resweep_len_c", 64'(nc), 64'd8);
      ra0 = 5'd7; ra1 = 5'd9;
      #1 chk("rst_clr_a", 64'(ifa.RDATA), 64'd0);
      chk("rst_clr_b", 64'(ifb.RDATA), 64'd0);
      ra0 = 5'd0; ra1 = 5'd3;
      #1 chk("rst_clr_b0", 64'(ifb.RDATA), 64'd0);
      cyc();

      // Four independent ports on the narrow instance.
      for (int i = 1; i < 8; i++) begin
         we_c = 1'b1; waddr_c = 3'(i); wdata_c = 16'(16'h1111 * i);
         cyc();
      end
      we_c = 1'b0;
      ra_c[0] = 3'd1; ra_c[1] = 3'd3; ra_c[2] = 3'd5; ra_c[3] = 3'd7;
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("c_odd%0d", p), 64'(ifc.RDATA[p*16 +: 16]), 64'(exp_c1[p]));
      cyc();
      ra_c[0] = 3'd2; ra_c[1] = 3'd4; ra_c[2] = 3'd6; ra_c[3] = 3'd0;
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("c_even%0d", p), 64'(ifc.RDATA[p*16 +: 16]), 64'(exp_c2[p]));
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port general-purpose register file for the MIPS core, replacing the fixed RegFile block. It provides NUM_RD asynchronous read ports, one synchronous write port, optional write-to-read bypass, and an optional hardwired-zero register 0. After reset, a hardware sweep clears every register, and READY holds the pipeline until the sweep completes. The block sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and writes to it are dropped
BYPASS, 1, 1 = a read of the register being written this cycle returns WDATA (write-first)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
WE  input  1  write enable
WADDR  input  ADDR_W  write register index
WDATA  input  DATA_W  write data
RADDR  input  NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
RDATA  output  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
READY  output  1  1 = clear sweep done, file accepts writes and returns valid reads

Behaviour:
- One clock, CLK. RST is synchronous and active-high.
- FSM states: CLEAR, RUN. Encoding is defined in the package.
- RST=1 at an edge: state <= CLEAR, clear counter <= 0, READY <= 0. This applies in any state, including mid-sweep; the sweep restarts at index 0.
- CLEAR: each cycle, reg[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1, write that entry, then state <= RUN and READY <= 1 on the same edge.
  - The sweep therefore takes exactly DEPTH cycles after RST deasserts. With defaults, READY rises on the 32nd edge after the first edge with RST=0.
  - cnt is ADDR_W+1 bits wide to avoid wrap ambiguity.
- CLEAR: WE is ignored. RDATA for every port is forced to 0.
- RUN: at a rising edge with WE=1, reg[WADDR] <= WDATA. When ZERO_REG=1 and WADDR=0, the write is dropped.
- Reads are combinational, with zero-cycle latency: RDATA[i] = reg[RADDR[i]].
- Read precedence, highest first:
  - (a) ZERO_REG=1 and RADDR[i]=0: returns 0.
  - (b) BYPASS=1, WE=1, READY=1 and WADDR==RADDR[i]: returns WDATA.
  - (c) otherwise returns the stored value.
- BYPASS=0: a same-cycle read returns the old value; the new value is visible from the next cycle.
- Several ports reading the same index is legal; all return identical data.
- READY stays 1 until the next RST. There is no other way back to CLEAR.
- Register array has no reset term other than the sweep. This allows LUTRAM inference: one write port, asynchronous reads, with the array replicated per read port.
- Reset values: READY=0. RDATA=0 while in CLEAR.

Decomposition:
- Package mips_rf_pkg:
  - rf_state_t enum {RF_CLEAR, RF_RUN}
  - default constants RF_DATA_W=32 and RF_ADDR_W=5
  - localparam helper for DEPTH
- Sub-module rf_read_port: one instance per read port, generated NUM_RD times. It is purely combinational and implements the zero / bypass / array-read precedence for a single port.
- The top level holds the array, the FSM, the clear counter and the write logic.

Test Plan:
- Reset sweep: RST=1 for 2 cycles, then 0 → READY=0 for exactly 32 cycles, then 1. All 32 registers read 0 on both ports. WE=1 with WADDR=5 and WDATA=0xDEAD during the sweep has no effect (reg5=0 after READY).
- Write/read: write reg7=0x12345678 with BYPASS=0 → same-cycle RDATA[0] for RADDR=7 shows the old 0. Next cycle, both ports reading 7 return 0x12345678.
- Bypass: BYPASS=1, WE=1, WADDR=9, WDATA=0xCAFEF00D, RADDR0=9, RADDR1=3 → RDATA0=0xCAFEF00D in the same cycle. RDATA1 equals the stored reg3.
- Zero register: WE=1, WADDR=0, WDATA=0xFFFFFFFF → RDATA=0 for RADDR=0 on the same cycle (bypass suppressed) and on all later cycles. With ZERO_REG=0, reg0 reads 0xFFFFFFFF next cycle.
- Reset mid-sweep: assert RST at sweep cycle 10 for 1 cycle → sweep restarts, and READY rises 32 cycles after RST deasserts. Mid-operation RST after data is written → all registers read 0 once READY=1.
- Parameter sweep: NUM_RD=4, ADDR_W=3, DATA_W=16 → sweep length 8 cycles. All four ports return independent values after writes reg1..reg7 = 0x1111·i.
